// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: accepts a length-prefixed, checksummed word
// stream, writes it to memory, reads it back to verify, then releases the CPU.
module imem_loader #(
    parameter int unsigned WADDR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic             mem_en_o,
    output logic [3:0]       mem_we_o,
    output logic [WADDR-1:0] mem_addr_o,
    output logic [31:0]      mem_data_o,
    input  logic [31:0]      mem_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             cpu_rst_o
);

    localparam int unsigned CW    = WADDR - 1;
    localparam int unsigned WORDS = 1 << (WADDR - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_VERIFY, S_DONE, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   vcnt_q, vcnt_d;
    logic [31:0]     ssum_q, ssum_d;
    logic [31:0]     rsum_q, rsum_d;
    logic [31:0]     rsum_nxt;
    logic            busy_d, done_d, err_d, cpu_rst_d;
    logic            hs;

    // Ready is a pure decode of the state register.
    assign s_ready_o = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign hs        = s_valid_i & s_ready_o;
    assign rsum_nxt  = rsum_q + mem_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            wcnt_q    <= '0;
            vcnt_q    <= '0;
            ssum_q    <= '0;
            rsum_q    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            cpu_rst_o <= 1'b1;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            wcnt_q    <= wcnt_d;
            vcnt_q    <= vcnt_d;
            ssum_q    <= ssum_d;
            rsum_q    <= rsum_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            err_o     <= err_d;
            cpu_rst_o <= cpu_rst_d;
        end
    end

    // Next-state, datapath updates and memory port drive.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wcnt_d     = wcnt_q;
        vcnt_d     = vcnt_q;
        ssum_d     = ssum_q;
        rsum_d     = rsum_q;
        mem_en_o   = 1'b0;
        mem_we_o   = 4'h0;
        mem_addr_o = '0;
        mem_data_o = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    wcnt_d  = '0;
                    vcnt_d  = '0;
                    ssum_d  = '0;
                    rsum_d  = '0;
                end
            end
            S_LEN: begin
                if (hs) begin
                    n_d = CW'(s_data_i);
                    if (s_data_i == 32'd0 || s_data_i > 32'(WORDS))
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Write commits on the handshake edge itself: zero added latency.
                if (hs) begin
                    mem_en_o   = 1'b1;
                    mem_we_o   = 4'hF;
                    mem_addr_o = {wcnt_q[CW-2:0], 2'b00};
                    mem_data_o = s_data_i;
                    ssum_d     = ssum_q + s_data_i;
                    wcnt_d     = wcnt_q + CW'(1);
                    if (wcnt_q + CW'(1) == n_q)
                        state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (hs)
                    state_d = (s_data_i != ssum_q) ? S_ERROR : S_VERIFY;
            end
            S_VERIFY: begin
                mem_en_o   = 1'b1;
                mem_addr_o = {vcnt_q[CW-2:0], 2'b00};
                rsum_d     = rsum_nxt;
                vcnt_d     = vcnt_q + CW'(1);
                if (vcnt_q == n_q - CW'(1))
                    state_d = (rsum_nxt == ssum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d == S_LEN) || (state_d == S_DATA) ||
                    (state_d == S_CSUM) || (state_d == S_VERIFY);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERROR);
        cpu_rst_d = (state_d != S_DONE);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load sessions plus reset/start corner cases.
module tb_imem_loader;

    localparam int unsigned WADDR = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic [31:0]      s_data_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic             mem_en_o;
    logic [3:0]       mem_we_o;
    logic [WADDR-1:0] mem_addr_o;
    logic [31:0]      mem_data_o;
    logic [31:0]      mem_data_i;
    logic             busy_o, done_o, err_o, cpu_rst_o;

    imem_loader #(.WADDR(WADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cpu_rst_o(cpu_rst_o)
    );

    always #5 clk = ~clk;

    // Memory model with optional corruption of word 1 on the read path.
    logic [31:0] mem [256];
    logic        corrupt = 1'b0;
    always @(posedge clk)
        if (mem_en_o && mem_we_o == 4'hF) mem[mem_addr_o[9:2]] <= mem_data_o;
    assign mem_data_i = (corrupt && mem_addr_o[9:2] == 8'd1) ? (mem[mem_addr_o[9:2]] ^ 32'h100)
                                                              : mem[mem_addr_o[9:2]];

    // Port monitor: counts writes/reads and flags out-of-sequence addresses.
    logic clr = 1'b0;
    int   wr_cnt, rd_cnt, addr_err;
    always @(posedge clk) begin
        if (clr) begin
            wr_cnt <= 0; rd_cnt <= 0; addr_err <= 0;
        end else if (mem_en_o) begin
            if (mem_we_o == 4'hF) begin
                if (mem_addr_o != WADDR'(wr_cnt * 4)) addr_err <= addr_err + 1;
                wr_cnt <= wr_cnt + 1;
            end else if (mem_we_o == 4'h0) begin
                if (mem_addr_o != WADDR'(rd_cnt * 4)) addr_err <= addr_err + 1;
                rd_cnt <= rd_cnt + 1;
            end else begin
                addr_err <= addr_err + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] n;
        bit          bad_csum;
        bit          corrupt;
        bit          gaps;
        bit          start_mid;
        bit          exp_done;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] pay [256];
    int          tests = 0;
    int          failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        int tmo;
        if (gaps) begin
            s_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        s_data_i  = w;
        s_valid_i = 1'b1;
        tmo = 0;
        while (!s_ready_o && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        chk("hs_timeout", 32'(tmo >= 100), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [31:0] sum;
        int          k, bad;
        bit          legal;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        corrupt = v.corrupt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk($sformatf("v%0d_busy_start", id), 32'(busy_o), 32'd1);
        chk($sformatf("v%0d_ready_start", id), 32'(s_ready_o), 32'd1);

        legal = (v.n != 0) && (v.n <= 32'd256);
        send_word(v.n, v.gaps);
        sum = 32'd0;
        if (legal) begin
            for (int i = 0; i < int'(v.n); i++) begin
                pay[i] = (v.n == 32'd3) ? 32'h11111111 * 32'(i + 1) : $urandom;
                sum += pay[i];
                if (v.start_mid && i == 1) start_i = 1'b1;
                send_word(pay[i], v.gaps);
                start_i = 1'b0;
            end
            send_word(v.bad_csum ? sum + 32'd1 : sum, v.gaps);
        end
        s_valid_i = 1'b0;

        k = 0;
        while (!done_o && !err_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_latency", id), 32'(k), 32'(v.exp_lat));
        chk($sformatf("v%0d_done", id), 32'(done_o), 32'(v.exp_done));
        chk($sformatf("v%0d_err", id), 32'(err_o), 32'(!v.exp_done));
        chk($sformatf("v%0d_cpu_rst", id), 32'(cpu_rst_o), 32'(!v.exp_done));
        chk($sformatf("v%0d_busy_end", id), 32'(busy_o), 32'd0);
        chk($sformatf("v%0d_ready_end", id), 32'(s_ready_o), 32'd0);
        chk($sformatf("v%0d_writes", id), 32'(wr_cnt), 32'(v.exp_wr));
        chk($sformatf("v%0d_reads", id), 32'(rd_cnt), 32'(v.exp_rd));
        chk($sformatf("v%0d_addr_seq", id), 32'(addr_err), 32'd0);
        if (legal) begin
            bad = 0;
            for (int i = 0; i < int'(v.n); i++) if (mem[i] !== pay[i]) bad++;
            chk($sformatf("v%0d_mem_content", id), 32'(bad), 32'd0);
        end
        corrupt = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(s_ready_o),  32'd0);
        chk({tag, "_mem_en"},  32'(mem_en_o),   32'd0);
        chk({tag, "_mem_we"},  32'(mem_we_o),   32'd0);
        chk({tag, "_addr"},    32'(mem_addr_o), 32'd0);
        chk({tag, "_wdata"},   mem_data_o,      32'd0);
        chk({tag, "_busy"},    32'(busy_o),     32'd0);
        chk({tag, "_done"},    32'(done_o),     32'd0);
        chk({tag, "_err"},     32'(err_o),      32'd0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst_o),  32'd1);
    endtask

    initial begin
        //          n       bad  cor  gap  smid done lat  wr   rd
        vecs[0] = '{32'd3,   0,   0,   0,   0,   1,   3,   3,   3};
        vecs[1] = '{32'd3,   1,   0,   0,   0,   0,   0,   3,   0};
        vecs[2] = '{32'd0,   0,   0,   0,   0,   0,   0,   0,   0};
        vecs[3] = '{32'd257, 0,   0,   0,   0,   0,   0,   0,   0};
        vecs[4] = '{32'd256, 0,   0,   1,   0,   1, 256, 256, 256};
        vecs[5] = '{32'd3,   0,   1,   0,   0,   0,   3,   3,   3};
        vecs[6] = '{32'd1,   0,   0,   1,   0,   1,   1,   1,   1};
        vecs[7] = '{32'd3,   0,   0,   0,   1,   1,   3,   3,   3};

        rst_n = 1'b0; start_i = 1'b0; s_data_i = '0; s_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of the data phase, after two words.
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        send_word(32'd3, 1'b0);
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        chk("mid_busy_before_rst", 32'(busy_o), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_rst");
        s_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory through one of its byte-strobed write ports. It accepts a length-prefixed, checksummed word stream over a valid/ready handshake and writes each payload word to consecutive word addresses. It then reads the image back through the same port's asynchronous read path and confirms the checksum. The CPU is held in reset until the image is verified.

## Interface
Parameters:
- WADDR, 10, byte-address width of the instruction memory; capacity is 2^WADDR bytes, i.e. 2^(WADDR-2) words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  single-cycle request to begin a load session.
- s_data_i  input  32  stream word.
- s_valid_i  input  1  stream word valid.
- s_ready_o  output  1  loader accepts a stream word.
- mem_en_o  output  1  memory port enable.
- mem_we_o  output  4  memory byte write strobes.
- mem_addr_o  output  WADDR  memory byte address, always word-aligned.
- mem_data_o  output  32  memory write data.
- mem_data_i  input  32  memory asynchronous read data; valid in the same cycle as mem_addr_o.
- busy_o  output  1  a session is in progress.
- done_o  output  1  image loaded and verified.
- err_o  output  1  the session failed.
- cpu_rst_o  output  1  active-high hold-in-reset to the CPU.

## Operation
- States: IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERROR.
- Reset values: state IDLE; cpu_rst_o=1; every other output 0. Internal registers: N, wcnt, vcnt, ssum and rsum, all cleared.
- IDLE, DONE, ERROR, on start_i=1:
  - Go to LEN.
  - Clear done_o, err_o, wcnt, vcnt, ssum, rsum.
  - Drive cpu_rst_o=1.
- start_i is ignored in LEN, DATA, CSUM and VERIFY.
- LEN, on handshake: latch N=s_data_i.
  - If N==0 or N>2^(WADDR-2), go to ERROR.
  - Otherwise go to DATA.
- DATA, each handshake:
  - Write the word: mem_en_o=1, mem_we_o=4'hF, mem_addr_o=wcnt<<2, mem_data_o=s_data_i.
  - ssum += s_data_i, with 32-bit wrap.
  - wcnt++.
  - After the Nth word, go to CSUM.
- CSUM, on handshake:
  - If s_data_i != ssum, go to ERROR.
  - Otherwise go to VERIFY.
- VERIFY, one read per cycle: mem_en_o=1, mem_we_o=0, mem_addr_o=vcnt<<2; rsum += mem_data_i; vcnt++.
  - On the cycle with vcnt==N-1, compare (rsum+mem_data_i) with ssum.
  - Equal: go to DONE. Unequal: go to ERROR.
- DONE: done_o=1, cpu_rst_o=0, busy_o=0.
- ERROR: err_o=1, cpu_rst_o=1, busy_o=0.
- busy_o=1 in LEN, DATA, CSUM and VERIFY.
- Outside DATA handshake cycles and VERIFY, the memory port is idle: mem_en_o=0, mem_we_o=0.
- Arithmetic:
  - All sums are 32-bit modulo 2^32.
  - wcnt and vcnt are WADDR-1 bits wide, so N=2^(WADDR-2) is representable.
  - No address wraps within a legal N.
- Reset mid-session returns all outputs to reset values at once, CPU held. Memory contents are undefined; a new start_i is required.

## Timing
- Handshake: s_valid_i & s_ready_o on a rising edge. s_ready_o is a pure function of state: 1 in LEN, DATA and CSUM, 0 elsewhere.
- s_valid_i may deassert between words with no penalty; nothing is lost or duplicated.
- The memory-port outputs in DATA are combinational from state, wcnt and s_valid_i. The write commits on the handshake edge, so there is zero added latency and one word per cycle at full throughput.
- start_i edge: busy_o=1 and s_ready_o=1 from the next cycle.
- Checksum handshake at edge t:
  - VERIFY occupies the N cycles after t.
  - done_o or err_o rises at edge t+N.
  - Total session length is 2N+2 cycles minimum.
- Early errors (bad N, checksum-word mismatch): err_o rises the cycle after the offending handshake. No VERIFY cycles occur.
- done_o, err_o and cpu_rst_o are registered with the state; they are glitch-free.

## Test plan
- WADDR=10. Stream 3, 0x11111111, 0x22222222, 0x33333333, checksum 0x66666666, valid held high.
  - Required: writes at byte addresses 0, 4, 8 with we=F.
  - Required: 3 read cycles at addresses 0, 4, 8; done_o=1 and cpu_rst_o=0 three cycles after the checksum handshake.
- Same stream with checksum 0x66666667.
  - Required: err_o=1 one cycle later, no VERIFY reads, cpu_rst_o stays 1.
- Length 0, then separately length 257.
  - Required: err_o one cycle after the length handshake, no memory writes.
- Length 256 with random payload and correct checksum, random valid gaps.
  - Required: exactly 256 writes at addresses 0..1020 step 4, memory matches the stream, done_o=1.
- Memory model corrupts the word at address 4 after the write phase.
  - Required: VERIFY mismatch, err_o=1 at the end of VERIFY.
- rst_n low during DATA after 2 words.
  - Required: all outputs at reset values immediately.
  - Then start_i pulse, full 3-word load, done_o=1.
- start_i pulsed during DATA: ignored, session completes normally.
